// File: rtl/spinet_host.sv
// Host-side SPI master for one spinet node: packet valid/ready client interface, one
// full-duplex WIDTH-bit word per SS assertion, paced by the node's txready/rxready pins.
module spinet_host #(
  parameter int WIDTH  = 16,
  parameter int ABITS  = 3,
  parameter int CLKDIV = 2,
  parameter int GAP    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [ABITS-1:0]            tx_dst,
  input  logic [WIDTH-2-2*ABITS-1:0]  tx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [ABITS-1:0]            rx_src,
  output logic [WIDTH-2-2*ABITS-1:0]  rx_data,
  output logic                        busy,
  output logic                        SCLK,
  output logic                        MOSI,
  output logic                        SS,
  input  logic                        MISO,
  input  logic                        node_txready,
  input  logic                        node_rxready
);

  localparam int PW   = WIDTH - 2 - 2*ABITS;
  localparam int CMAX = (GAP > CLKDIV) ? GAP : CLKDIV;
  localparam int CW   = $clog2(CMAX);
  localparam int NW   = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAPWAIT} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     c, c_nx;
  logic [NW-1:0]     n, n_nx;
  logic [WIDTH-1:0]  fsh, fsh_nx;
  logic [WIDTH-1:0]  rsh, rsh_nx;
  logic [WIDTH-1:0]  tx_word, tx_word_nx;
  logic              tx_pend, tx_pend_nx;
  logic              carry, carry_nx;
  logic              ss, ss_nx, sclk, sclk_nx, mosi, mosi_nx, busy_r, busy_nx;
  logic              rx_valid_r, rx_valid_nx;
  logic [ABITS-1:0]  rx_src_r, rx_src_nx;
  logic [PW-1:0]     rx_data_r, rx_data_nx;
  logic              txr_m, txr_s, rxr_m, rxr_s;
  logic              last;

  assign tx_ready = ~tx_pend;
  assign rx_valid = rx_valid_r;
  assign rx_src   = rx_src_r;
  assign rx_data  = rx_data_r;
  assign busy     = busy_r;
  assign SCLK     = sclk;
  assign MOSI     = mosi;
  assign SS       = ss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txr_m <= 1'b0;
      txr_s <= 1'b0;
      rxr_m <= 1'b0;
      rxr_s <= 1'b0;
    end else begin
      txr_m <= node_txready;
      txr_s <= txr_m;
      rxr_m <= node_rxready;
      rxr_s <= rxr_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= GAPWAIT;
      c          <= '0;
      n          <= '0;
      fsh        <= '0;
      rsh        <= '0;
      tx_word    <= '0;
      tx_pend    <= 1'b0;
      carry      <= 1'b0;
      ss         <= 1'b1;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      busy_r     <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_src_r   <= '0;
      rx_data_r  <= '0;
    end else begin
      state      <= state_nx;
      c          <= c_nx;
      n          <= n_nx;
      fsh        <= fsh_nx;
      rsh        <= rsh_nx;
      tx_word    <= tx_word_nx;
      tx_pend    <= tx_pend_nx;
      carry      <= carry_nx;
      ss         <= ss_nx;
      sclk       <= sclk_nx;
      mosi       <= mosi_nx;
      busy_r     <= busy_nx;
      rx_valid_r <= rx_valid_nx;
      rx_src_r   <= rx_src_nx;
      rx_data_r  <= rx_data_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    c_nx        = c;
    n_nx        = n;
    fsh_nx      = fsh;
    rsh_nx      = rsh;
    tx_word_nx  = tx_word;
    tx_pend_nx  = tx_pend;
    carry_nx    = carry;
    ss_nx       = ss;
    sclk_nx     = sclk;
    mosi_nx     = mosi;
    busy_nx     = busy_r;
    rx_valid_nx = rx_valid_r;
    rx_src_nx   = rx_src_r;
    rx_data_nx  = rx_data_r;
    last        = (c == CW'(CLKDIV - 1));

    if (rx_valid_r && rx_ready)
      rx_valid_nx = 1'b0;
    // SRC is left zero; the node fills in its own address.
    if (tx_valid && !tx_pend) begin
      tx_pend_nx = 1'b1;
      tx_word_nx = {1'b1, 1'b0, tx_dst, {ABITS{1'b0}}, tx_data};
    end

    case (state)
      IDLE: begin
        // txr_s gates receive-only frames too: every frame overwrites the node tx buffer.
        if (txr_s && !rx_valid_r && (tx_pend || rxr_s)) begin
          state_nx = SETUP;
          c_nx     = '0;
          n_nx     = NW'(WIDTH - 1);
          fsh_nx   = tx_pend ? tx_word : '0;
          carry_nx = tx_pend;
          mosi_nx  = tx_pend & tx_word[WIDTH-1];
          ss_nx    = 1'b0;
          busy_nx  = 1'b1;
        end
      end
      SETUP: begin
        if (last) begin
          state_nx = HIGH;
          c_nx     = '0;
          sclk_nx  = 1'b1;
        end else begin
          c_nx = c + CW'(1);
        end
      end
      HIGH: begin
        if (last) begin
          state_nx = LOW;
          c_nx     = '0;
          sclk_nx  = 1'b0;
          rsh_nx   = {rsh[WIDTH-2:0], MISO};
        end else begin
          c_nx = c + CW'(1);
        end
      end
      LOW: begin
        if (last) begin
          c_nx = '0;
          if (n != '0) begin
            state_nx = HIGH;
            sclk_nx  = 1'b1;
            n_nx     = n - NW'(1);
            fsh_nx   = fsh << 1;
            mosi_nx  = fsh[WIDTH-2];
          end else begin
            state_nx = HOLD;
          end
        end else begin
          c_nx = c + CW'(1);
        end
      end
      HOLD: begin
        if (last) begin
          state_nx = GAPWAIT;
          c_nx     = '0;
          ss_nx    = 1'b1;
          busy_nx  = 1'b0;
          mosi_nx  = 1'b0;
          carry_nx = 1'b0;
          if (carry)
            tx_pend_nx = 1'b0;
          if (rsh[WIDTH-1]) begin
            rx_valid_nx = 1'b1;
            rx_src_nx   = rsh[WIDTH-3-ABITS -: ABITS];
            rx_data_nx  = rsh[PW-1:0];
          end
        end else begin
          c_nx = c + CW'(1);
        end
      end
      GAPWAIT: begin
        if (c == CW'(GAP - 1)) begin
          state_nx = IDLE;
          c_nx     = '0;
        end else begin
          c_nx = c + CW'(1);
        end
      end
      default: state_nx = GAPWAIT;
    endcase
  end

endmodule

// File: tb/tb_spinet_host.sv
// Scoreboard bench for spinet_host: stimulus queues expected SPI words and received
// packets; independent monitors compare each SS frame and each rx_valid against them.
module tb_spinet_host;

  localparam int WIDTH  = 16;
  localparam int ABITS  = 3;
  localparam int CLKDIV = 2;
  localparam int GAP    = 16;
  localparam int PW     = WIDTH - 2 - 2*ABITS;
  localparam int FRAME  = CLKDIV * (2*WIDTH + 2);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic [ABITS-1:0] tx_dst = '0;
  logic [PW-1:0]    tx_data = '0;
  logic             rx_valid;
  logic             rx_ready = 1'b0;
  logic [ABITS-1:0] rx_src;
  logic [PW-1:0]    rx_data;
  logic             busy, SCLK, MOSI, SS;
  logic             MISO = 1'b0;
  logic             node_txready = 1'b0;
  logic             node_rxready = 1'b0;

  always #5 clk = ~clk;

  spinet_host #(.WIDTH(WIDTH), .ABITS(ABITS), .CLKDIV(CLKDIV), .GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dst(tx_dst), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src(rx_src), .rx_data(rx_data),
    .busy(busy), .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO),
    .node_txready(node_txready), .node_rxready(node_rxready)
  );

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0]    exp_mosi[$];
  logic [ABITS+PW-1:0] exp_rx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Node slave model: reloads its word when SS falls, shifts MISO out on SCLK rising edges.
  logic [WIDTH-1:0] slave_word = '0;
  logic [WIDTH-1:0] miso_sh = '0;
  always @(negedge SS or posedge SCLK) begin
    if (SCLK) begin
      MISO    = miso_sh[WIDTH-1];
      miso_sh = miso_sh << 1;
    end else begin
      miso_sh = slave_word;
    end
  end

  int               frame_count = 0;
  int               cur_bits = 0;
  int               len, gap;
  logic [WIDTH-1:0] cap, w;
  logic             prev_sclk, first, aborted, have_prev;
  longint           t_rise;

  initial begin : frame_mon
    have_prev = 1'b0;
    t_rise    = 0;
    forever begin
      @(negedge SS);
      if (have_prev) begin
        gap = int'(($time - t_rise + 5) / 10);
        check("ss_gap_min", 32'(gap >= GAP ? GAP : gap), 32'(GAP));
      end
      frame_count++;
      cur_bits  = 0;
      cap       = '0;
      len       = 0;
      prev_sclk = 1'b0;
      first     = 1'b1;
      forever begin
        @(negedge clk);
        if (SS !== 1'b0) break;
        if (first) begin
          check("busy_in_frame", 32'(busy), 32'd1);
          first = 1'b0;
        end
        len++;
        if (prev_sclk && !SCLK) begin
          cap = {cap[WIDTH-2:0], MOSI};
          cur_bits++;
        end
        prev_sclk = SCLK;
        if (len > 4*FRAME) begin
          timeout("frame_end");
          break;
        end
      end
      t_rise    = $time;
      have_prev = 1'b1;
      aborted   = (rst === 1'b1);
      if (exp_mosi.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame: mosi 0x%0h with no word queued", cap);
      end else begin
        w = exp_mosi.pop_front();
        if (!aborted) begin
          check("mosi_word", 32'(cap), 32'(w));
          check("bit_count", 32'(cur_bits), 32'(WIDTH));
          check("ss_low_cycles", 32'(len), 32'(FRAME));
          check("busy_after_frame", 32'(busy), 32'd0);
        end
      end
    end
  end

  logic                rxv_prev = 1'b0;
  logic [ABITS+PW-1:0] rx_exp;
  always @(negedge clk) begin
    if (rx_valid && !rxv_prev) begin
      if (exp_rx.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rx: src %0d data 0x%0h", rx_src, rx_data);
      end else begin
        rx_exp = exp_rx.pop_front();
        check("rx_src", 32'(rx_src), 32'(rx_exp[ABITS+PW-1:PW]));
        check("rx_data", 32'(rx_data), 32'(rx_exp[PW-1:0]));
      end
    end
    rxv_prev = rx_valid;
  end

  task automatic send(input logic [ABITS-1:0] d, input logic [PW-1:0] p, input logic [WIDTH-1:0] word);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (tx_ready) break;
    end
    if (!tx_ready) timeout("send_tx_ready");
    exp_mosi.push_back(word);
    tx_valid = 1'b1;
    tx_dst   = d;
    tx_data  = p;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (frame_count >= target && SS) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(name);
    repeat (GAP + 4) @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int fc, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (frame_count > fc) break;
    end
    check(name, 32'(frame_count > fc), 32'd1);
  endtask

  task automatic wait_rx(input string name);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (rx_valid) break;
    end
    if (!rx_valid) timeout(name);
  endtask

  task automatic pulse_rx_ready();
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  int fc;

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    check("rst_SS", 32'(SS), 32'd1);
    check("rst_SCLK", 32'(SCLK), 32'd0);
    check("rst_MOSI", 32'(MOSI), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_src", 32'(rx_src), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    node_txready = 1'b1;

    // Plain send, node returns zeros
    send(3'd5, 8'hA5, 16'hA8A5);
    wait_frames(1, "send_frame");
    check("send_tx_ready_back", 32'(tx_ready), 32'd1);
    check("send_no_rx", 32'(rx_valid), 32'd0);

    // Receive-only frame
    slave_word = 16'h933C;
    exp_mosi.push_back(16'h0000);
    exp_rx.push_back({3'd3, 8'h3C});
    node_rxready = 1'b1;
    wait_rx("recv_rx_valid");
    node_rxready = 1'b0;
    slave_word   = '0;
    repeat (10) @(posedge clk);
    #1;
    check("recv_rx_valid_held", 32'(rx_valid), 32'd1);
    pulse_rx_ready();
    check("recv_rx_valid_clear", 32'(rx_valid), 32'd0);
    wait_frames(2, "recv_frame");

    // node_txready low blocks the frame
    node_txready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    send(3'd1, 8'h12, 16'h8812);
    fc = frame_count;
    repeat (100) @(posedge clk);
    #1;
    check("blocked_no_frame", 32'(frame_count), 32'(fc));
    node_txready = 1'b1;
    wait_start(fc, 3 + GAP, "blocked_release_start");
    wait_frames(fc + 1, "blocked_frame");

    // rx_valid backpressure holds off further frames
    slave_word = 16'h8655;
    exp_mosi.push_back(16'h0000);
    exp_rx.push_back({3'd6, 8'h55});
    node_rxready = 1'b1;
    wait_rx("bp_rx_valid");
    slave_word = '0;
    send(3'd2, 8'h77, 16'h9077);
    fc = frame_count;
    repeat (60) @(posedge clk);
    #1;
    check("bp_no_frame", 32'(frame_count), 32'(fc));
    node_rxready = 1'b0;
    pulse_rx_ready();
    wait_start(fc, 3 + GAP, "bp_resume_start");
    wait_frames(fc + 1, "bp_frame");

    // Back-to-back packets
    fc = frame_count;
    send(3'd4, 8'h01, 16'hA001);
    send(3'd7, 8'hFE, 16'hB8FE);
    wait_frames(fc + 2, "b2b_frames");

    // Reset in the middle of a frame
    fc = frame_count;
    send(3'd3, 8'h5A, 16'h985A);
    wait_start(fc, 200, "abort_frame_start");
    for (int i = 0; i < 400 && cur_bits < 7; i++) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_SS", 32'(SS), 32'd1);
    check("abort_SCLK", 32'(SCLK), 32'd0);
    check("abort_tx_ready", 32'(tx_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    send(3'd6, 8'hC3, 16'hB0C3);
    wait_frames(fc + 2, "post_abort_frame");

    check("mosi_queue_drained", 32'(exp_mosi.size()), 32'd0);
    check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
